note_tick_sequencer: RTL
========================

# note_tick_sequencer

Steps through a song table at the rate of the 24 Hz note clock produced by the note clock divider, and hands one note at a time to the tone generator. It synchronizes and edge-detects the slow note clock, fetches note entries from a synchronous song ROM, presents each note over a valid/ready handshake, and holds it for a programmed number of note ticks. It sits between the note clock divider, the song ROM and the tone generator in the 100 MHz domain.

## Interface
- NOTE_W, 6: note code width (tone generator index)
- DUR_W, 4: duration field width, in note ticks
- ADDR_W, 6: song ROM address width; song length 2^ADDR_W entries
- clkin  input  1  100 MHz master clock
- reset_n  input  1  asynchronous, active-low reset
- note_clk  input  1  24 Hz note clock level from the divider; synchronized internally
- start  input  1  one-cycle request to start playback from entry 0
- stop  input  1  one-cycle request to abort playback
- rom_en  output  1  song ROM read enable
- rom_addr  output  ADDR_W  song ROM address
- rom_data  input  NOTE_W+DUR_W  {note, duration}; valid the cycle after rom_en
- note_code  output  NOTE_W  current note to tone generator
- note_valid  output  1  note_code valid
- note_ready  input  1  tone generator accepts note_code
- playing  output  1  high in any state except IDLE and DONE
- done  output  1  high while in DONE

## Operation
- Tick: note_clk through 2-flop synchronizer, then edge register; tick = one-cycle pulse per rising edge.
- States: IDLE, FETCH, WAIT, PRESENT, HOLD, DONE.
- IDLE: start → FETCH, index = 0.
- FETCH: rom_en = 1, rom_addr = index; → WAIT.
- WAIT: capture rom_data. Duration 0 = end marker → DONE. Otherwise note_code ← note, dur_cnt ← duration, → PRESENT.
- PRESENT: note_valid = 1, note_code stable until note_ready sampled high; then → HOLD, note_valid drops next cycle.
- HOLD: each tick decrements dur_cnt; tick with dur_cnt == 1 → advance.
- Advance: index == 2^ADDR_W − 1 → end of song (DONE); else index + 1, → FETCH.
- Ticks outside HOLD are discarded; duration counts from handshake completion.
- DONE: start → FETCH, index = 0.
- stop in any state except IDLE → IDLE next cycle, note_valid = 0, index = 0. stop and start same cycle: stop wins.
- note_ready outside PRESENT: ignored.

## Timing
- Reset values: rom_en 0, rom_addr 0, note_code 0, note_valid 0, playing 0, done 0, state IDLE, dur_cnt 0, synchronizer flops 0.
- Reset mid-operation: all outputs return to reset values asynchronously; a note_clk high at release does not produce a tick until its next rising edge.
- note_clk rising edge → tick asserted 3 clkin cycles later (2 sync + edge detect).
- start in cycle N → rom_en cycle N+1 → note_valid cycle N+3.
- Handshake accepted cycle M → HOLD from M+1; note held exactly `duration` ticks.
- Last tick of a note → next note_valid 3 cycles later; note_valid low for at least those 3 cycles.

## Configuration
- SEQ_LOOP_EN defined: end marker, or advance past index 2^ADDR_W − 1, restarts at index 0 (→ FETCH) instead of DONE; done never asserts. An end marker at index 0 still goes to DONE.
- SEQ_LOOP_EN undefined: behaviour as in Operation; song plays once and stops in DONE.

## Test plan
- ROM {5,2},{9,1},{0,0}, note_ready tied high, start → note 5 valid 3 cycles after start, held 2 ticks; note 9 held 1 tick; done = 1, playing = 0.
- note_ready held low 500 cycles during PRESENT with note 5 → note_valid and note_code = 5 stable throughout; ticks in this window not counted; full 2 ticks counted after acceptance.
- stop during HOLD of the second note → IDLE next cycle, note_valid 0, playing 0; following start replays from entry 0.
- start and stop asserted same cycle in IDLE → remains IDLE, rom_en never asserted.
- All 64 entries nonzero duration 1 → without SEQ_LOOP_EN DONE after entry 63; with SEQ_LOOP_EN rom_addr wraps 63 → 0 and done stays 0.
- reset_n pulsed low during PRESENT → all outputs 0 immediately; no tick reported while note_clk stays high after release.

Source files
------------

// File: rtl/note_tick_sequencer_if.sv
// note_tick_sequencer_if
//   Groups the sequencer's two external buses: the synchronous song ROM read
//   port and the valid/ready note handshake towards the tone generator.
//   Parameters:
//     NOTE_W  note code width
//     DUR_W   duration field width (note ticks)
//     ADDR_W  song ROM address width
//   Signals:
//     rom_en      sequencer -> ROM   read enable
//     rom_addr    sequencer -> ROM   read address
//     rom_data    ROM -> sequencer   {note, duration}, valid the cycle after rom_en
//     note_code   sequencer -> tone  current note
//     note_valid  sequencer -> tone  note_code valid
//     note_ready  tone -> sequencer  tone generator accepts note_code
//   Modports: master (sequencer side), slave (ROM / tone generator side).
interface note_tick_sequencer_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4,
  parameter int ADDR_W = 6
);
  logic                    rom_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note_code;
  logic                    note_valid;
  logic                    note_ready;

  modport master (
    output rom_en, rom_addr, note_code, note_valid,
    input  rom_data, note_ready
  );

  modport slave (
    input  rom_en, rom_addr, note_code, note_valid,
    output rom_data, note_ready
  );
endinterface

// File: rtl/note_tick_sequencer.sv
// note_tick_sequencer
//   Steps through a song table at the rate of the slow note clock. The note
//   clock level is synchronized and edge-detected into a one-cycle tick; each
//   song entry is fetched from a synchronous ROM, offered to the tone generator
//   over valid/ready, then held for its programmed number of ticks.
//   Optional feature macro: SEQ_LOOP_EN -- when defined, the song restarts at
//   entry 0 instead of stopping in DONE (an end marker at entry 0 still stops).
//   Ports:
//     clkin_i     100 MHz master clock
//     reset_n_i   asynchronous active-low reset
//     note_clk_i  note clock level from the divider (asynchronous to clkin_i)
//     start_i     one-cycle request to play from entry 0
//     stop_i      one-cycle request to abort playback (wins over start_i)
//     seq_if      master side of the ROM bus and note handshake
//     playing_o   high in any state except IDLE and DONE
//     done_o      high while in DONE
module note_tick_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                 clkin_i,
  input  logic                 reset_n_i,
  input  logic                 note_clk_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  note_tick_sequencer_if.master seq_if,
  output logic                 playing_o,
  output logic                 done_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [NOTE_W-1:0] note_q, note_d;

  logic       sync1_q, sync2_q, edge_q, armed_q, tick_q;
  logic [1:0] fill_q;

  logic [NOTE_W-1:0] romNote;
  logic [DUR_W-1:0]  romDur;

  assign romNote = seq_if.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign romDur  = seq_if.rom_data[DUR_W-1:0];

  assign seq_if.rom_en     = (state_q == FETCH);
  assign seq_if.rom_addr   = index_q;
  assign seq_if.note_code  = note_q;
  assign seq_if.note_valid = (state_q == PRESENT);
  assign playing_o         = (state_q != IDLE) && (state_q != DONE);
  assign done_o            = (state_q == DONE);

  // Tick generation. fill_q marks when the synchronizer holds a real sample of
  // note_clk; armed_q only goes high once a genuine low level has been seen,
  // so a note clock that is already high when reset releases does not count
  // as a rising edge.
  always_ff @(posedge clkin_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= note_clk_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      tick_q  <= sync2_q & ~edge_q & armed_q;
    end
  end

  // Sequencer next-state logic. stop_i is checked first so it overrides any
  // transition, including a start_i in the same cycle.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    dur_d   = dur_q;
    note_d  = note_q;
    if (stop_i && (state_q != IDLE)) begin
      state_d = IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i && !stop_i) begin
            state_d = FETCH;
            index_d = '0;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          if (romDur == '0) begin
`ifdef SEQ_LOOP_EN
            if (index_q != '0) begin
              index_d = '0;
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            note_d  = romNote;
            dur_d   = romDur;
            state_d = PRESENT;
          end
        end
        PRESENT: begin
          if (seq_if.note_ready) state_d = HOLD;
        end
        HOLD: begin
          if (tick_q) begin
            dur_d = dur_q - DUR_ONE;
            if (dur_q == DUR_ONE) begin
              if (index_q == '1) begin
`ifdef SEQ_LOOP_EN
                index_d = '0;
                state_d = FETCH;
`else
                state_d = DONE;
`endif
              end else begin
                index_d = index_q + 1'b1;
                state_d = FETCH;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      index_q <= '0;
      dur_q   <= '0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
    end
  end

endmodule
